// File: rtl/ex_stage_pipelined.sv
// Execute stage of the pipelined ARMv8 core: operand forwarding, ALU decode and
// compute, branch target, an iterative shift-add MUL and the EX/MEM register.
module ex_stage_pipelined #(
  parameter int XLEN   = 64,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  output logic              ex_ready,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   read_data_1,
  input  logic [XLEN-1:0]   read_data_2,
  input  logic [XLEN-1:0]   sign_extend_out,
  input  logic              alu_src,
  input  logic [1:0]        alu_op,
  input  logic [10:0]       opcode,
  input  logic [RD_W-1:0]   rd,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [1:0]        forward_a,
  input  logic [1:0]        forward_b,
  input  logic [XLEN-1:0]   exmem_fwd_data,
  input  logic [XLEN-1:0]   wb_fwd_data,
  input  logic              flush,
  input  logic              mem_stall,
  output logic              exmem_valid,
  output logic [XLEN-1:0]   exmem_result,
  output logic              exmem_zero,
  output logic [XLEN-1:0]   exmem_store_data,
  output logic [XLEN-1:0]   exmem_branch_target,
  output logic [RD_W-1:0]   exmem_rd,
  output logic [CTRL_W-1:0] exmem_ctrl,
  output logic              state_dbg
);
  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  localparam logic [10:0] OPC_ADD = 11'b10001011000;
  localparam logic [10:0] OPC_SUB = 11'b11001011000;
  localparam logic [10:0] OPC_AND = 11'b10001010000;
  localparam logic [10:0] OPC_ORR = 11'b10101010000;
  localparam logic [10:0] OPC_MUL = 11'b10011011000;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_e;
  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_ORR, ALU_PASS_B, ALU_MUL, ALU_ILLEGAL
  } alu_ctrl_e;

  state_e            state_q, state_d;
  alu_ctrl_e         alu_ctrl;
  logic [XLEN-1:0]   op_a, b_fwd, op_b, alu_result, branch_target;
  logic              exmem_free, accept, is_mul;
  logic [XLEN-1:0]   mul_a_q, mul_b_q, acc_q, partial, acc_sum;
  logic [XLEN-1:0]   mul_store_q, mul_target_q;
  logic [RD_W-1:0]   mul_rd_q;
  logic [CTRL_W-1:0] mul_ctrl_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              cnt_last, mul_done;

  function automatic logic [XLEN-1:0] fwd_pick(input logic [1:0] sel,
                                               input logic [XLEN-1:0] rf,
                                               input logic [XLEN-1:0] ex,
                                               input logic [XLEN-1:0] wb);
    case (sel)
      2'b10:   return ex;
      2'b01:   return wb;
      default: return rf;
    endcase
  endfunction

  assign op_a          = fwd_pick(forward_a, read_data_1, exmem_fwd_data, wb_fwd_data);
  assign b_fwd         = fwd_pick(forward_b, read_data_2, exmem_fwd_data, wb_fwd_data);
  assign op_b          = alu_src ? sign_extend_out : b_fwd;
  assign branch_target = pc + (sign_extend_out << 2);

  always_comb begin
    alu_ctrl = ALU_ILLEGAL;
    case (alu_op)
      2'b00: alu_ctrl = ALU_ADD;
      2'b01: alu_ctrl = ALU_PASS_B;
      2'b10: begin
        case (opcode)
          OPC_ADD: alu_ctrl = ALU_ADD;
          OPC_SUB: alu_ctrl = ALU_SUB;
          OPC_AND: alu_ctrl = ALU_AND;
          OPC_ORR: alu_ctrl = ALU_ORR;
          OPC_MUL: alu_ctrl = ALU_MUL;
          default: alu_ctrl = ALU_ILLEGAL;
        endcase
      end
      default: alu_ctrl = ALU_ILLEGAL;
    endcase
  end

  // MUL never goes through this path; it has its own iterative datapath.
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      ALU_ADD:    alu_result = op_a + op_b;
      ALU_SUB:    alu_result = op_a - op_b;
      ALU_AND:    alu_result = op_a & op_b;
      ALU_ORR:    alu_result = op_a | op_b;
      ALU_PASS_B: alu_result = op_b;
      default:    alu_result = '0;
    endcase
  end

  assign is_mul   = (alu_ctrl == ALU_MUL);
  assign partial  = mul_b_q[cnt_q] ? (mul_a_q << cnt_q) : '0;
  assign acc_sum  = acc_q + partial;
  assign cnt_last = (cnt_q == CNT_LAST);

  // Handshake: an ID/EX instruction transfers on a rising edge where id_valid
  // and ex_ready are both 1 and flush is 0; otherwise ID/EX must hold it.
  // EX/MEM contents transfer downstream on any edge where mem_stall is 0.
  always_comb begin
    state_d    = state_q;
    exmem_free = !exmem_valid || !mem_stall;
    ex_ready   = (state_q == S_IDLE) && exmem_free;
    accept     = id_valid && ex_ready && !flush;
    mul_done   = (state_q == S_MUL) && cnt_last && exmem_free;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (accept && is_mul) state_d = S_MUL;
        S_MUL:   if (mul_done) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Multiplier: operands and pass-through fields are captured at acceptance
  // so the front of the pipe may change while the product is built.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      mul_store_q  <= '0;
      mul_target_q <= '0;
      mul_rd_q     <= '0;
      mul_ctrl_q   <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else if (accept && is_mul) begin
      mul_a_q      <= op_a;
      mul_b_q      <= op_b;
      acc_q        <= '0;
      cnt_q        <= '0;
      mul_store_q  <= b_fwd;
      mul_target_q <= branch_target;
      mul_rd_q     <= rd;
      mul_ctrl_q   <= ctrl_in;
    end else if (mul_done) begin
      cnt_q <= '0;
    end else if (state_q == S_MUL && !cnt_last) begin
      acc_q <= acc_sum;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      exmem_valid         <= 1'b0;
      exmem_result        <= '0;
      exmem_zero          <= 1'b0;
      exmem_store_data    <= '0;
      exmem_branch_target <= '0;
      exmem_rd            <= '0;
      exmem_ctrl          <= '0;
    end else if (flush) begin
      exmem_valid <= 1'b0;
    end else if (exmem_free) begin
      if (accept && !is_mul) begin
        exmem_valid         <= 1'b1;
        exmem_result        <= alu_result;
        exmem_zero          <= (alu_result == '0);
        exmem_store_data    <= b_fwd;
        exmem_branch_target <= branch_target;
        exmem_rd            <= rd;
        exmem_ctrl          <= ctrl_in;
      end else if (mul_done) begin
        exmem_valid         <= 1'b1;
        exmem_result        <= acc_sum;
        exmem_zero          <= (acc_sum == '0);
        exmem_store_data    <= mul_store_q;
        exmem_branch_target <= mul_target_q;
        exmem_rd            <= mul_rd_q;
        exmem_ctrl          <= mul_ctrl_q;
      end else begin
        exmem_valid <= 1'b0;
      end
    end
  end
endmodule
